pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the processor datapath, carrying NFIELDS fields of WIDTH bits each (default: PC, A, B, IR).
- Adds valid/ready flow control with a 2-entry skid buffer, so stalls never create a combinational ready path between stages.
- Adds flush with bubble insertion: the IR field is forced to a NOP encoding.
- Sits between each pair of pipeline stages (F/D, D/X, X/M, M/W).

Parameters:
- WIDTH, 32, bits per field
- NFIELDS, 4, number of fields packed into the data bus
- NOP_FIELD, 3, index of the field that receives NOP_VALUE on flush (field i occupies bits [i*WIDTH +: WIDTH])
- NOP_VALUE, 0, encoding written into field NOP_FIELD when a bubble is inserted

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  synchronous active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept a word this cycle
- in_data  in  NFIELDS*WIDTH  packed upstream fields
- flush  in  1  discard all held words and insert a bubble
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  NFIELDS*WIDTH  packed fields, driven directly from the main register
- count  out  2  occupancy: 0, 1 or 2

Behaviour:
- Storage: main register (main_q, main_v) and skid register (skid_q, skid_v).
  - out_data = main_q; out_valid = main_v.
  - in_ready = ~skid_v, registered state only, with no combinational dependence on out_ready or in_valid.
  - count = main_v + skid_v.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Priority: clr > flush > normal operation.
- Reset (clr=1 at edge):
  - main_v=0, skid_v=0, count=0, in_ready=1.
  - main_q and skid_q all zero except field NOP_FIELD = NOP_VALUE.
  - Applies regardless of state, including mid-transfer or while FULL.
- States: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - EMPTY, accept: main<=in_data, main_v<=1 -> ONE.
  - EMPTY, no accept: hold.
  - ONE, accept & drain: main<=in_data -> ONE. Sustains 1 word/cycle.
  - ONE, accept & ~drain: skid<=in_data, skid_v<=1 -> FULL.
  - ONE, ~accept & drain: main_v<=0 -> EMPTY. main_q keeps its last value.
  - ONE, neither: hold.
  - FULL, drain: main<=skid_q, skid_v<=0 -> ONE. in_ready was 0, so no accept is possible.
  - FULL, ~drain: hold; in_ready stays 0.
- Latency: an accepted word appears on out_data/out_valid the cycle after acceptance if main is free, otherwise after the current main word drains.
- Ordering: strict FIFO order; no word is duplicated or lost except by flush or clr.
- Flush (flush=1, clr=0):
  - main_v<=0, skid_v<=0.
  - main_q: field NOP_FIELD <= NOP_VALUE, all other fields <= 0.
  - Any word presented with accept in the same cycle is dropped.
  - A drain in the same cycle still completes downstream (the word was consumed), but that does not affect the stage's state.
  - After flush: EMPTY, in_ready=1.
- Hold rule: while out_valid=1 and out_ready=0, out_data is stable.
- Data path: no arithmetic; fields are passed bit-exact.

Test Plan:
- Reset: drive clr=1 with junk in_data and in_valid=1 for 2 cycles -> out_valid=0, count=0, in_ready=1, IR field=NOP_VALUE, other fields 0.
- Streaming: out_ready=1, feed PC=0x100,0x104,0x108,0x10C on consecutive cycles -> identical words on out_data 1 cycle later, out_valid continuously 1, in_ready never 0.
- Backpressure:
  - Feed A=0x11 then A=0x22 with out_ready=0 -> count=2, in_ready=0, out_data A=0x11 held stable.
  - Raise out_ready -> 0x11 then 0x22 delivered in order, count 2->1->0.
- Flush while FULL with in_valid=1 (A=0x33) -> next cycle out_valid=0, count=0, IR field=NOP_VALUE, 0x33 never emitted.
- clr while ONE with flush=1 and out_ready=1 in the same cycle -> reset values; the word accepted before clr never appears afterward.
- Random valid/ready (≥10k cycles, NFIELDS=2, WIDTH=8) against a reference queue model:
  - no loss, duplication or reorder;
  - in_ready == (count<2) every cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control, a 2-entry skid
// buffer (main + skid) and flush that turns the held word into a bubble.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               NFIELDS   = 4,
  parameter int               NOP_FIELD = 3,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NFIELDS*WIDTH-1:0]   in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NFIELDS*WIDTH-1:0]   out_data,
  output logic [1:0]                 count
);

  localparam int DW = NFIELDS * WIDTH;

  // Occupancy states, encoded as {skidValid, mainValid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [DW-1:0] mainData_q, mainData_d;
  logic [DW-1:0] skidData_q, skidData_d;
  logic          mainValid_q, mainValid_d;
  logic          skidValid_q, skidValid_d;
  logic [DW-1:0] bubble;
  logic          accept;
  logic          drain;

  always_comb begin
    bubble = '0;
    bubble[NOP_FIELD*WIDTH +: WIDTH] = NOP_VALUE;
  end

  // Ready depends only on registered state, so stalls never chain combinationally upstream
  assign in_ready  = ~skidValid_q;
  assign out_valid = mainValid_q;
  assign out_data  = mainData_q;
  assign count     = {1'b0, mainValid_q} + {1'b0, skidValid_q};
  assign accept    = in_valid & in_ready;
  assign drain     = mainValid_q & out_ready;

  always_comb begin
    mainData_d  = mainData_q;
    skidData_d  = skidData_q;
    mainValid_d = mainValid_q;
    skidValid_d = skidValid_q;
    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
      mainData_d  = bubble;
    end else begin
      case ({skidValid_q, mainValid_q})
        ST_EMPTY: begin
          if (accept) begin
            mainData_d  = in_data;
            mainValid_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            mainData_d = in_data;
          end else if (accept) begin
            skidData_d  = in_data;
            skidValid_d = 1'b1;
          end else if (drain) begin
            mainValid_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (drain) begin
            mainData_d  = skidData_q;
            skidValid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mainData_q  <= bubble;
      skidData_q  <= bubble;
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
    end else begin
      mainData_q  <= mainData_d;
      skidData_q  <= skidData_d;
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
    end
  end

endmodule
